// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encoding and byte-enable helper for the
// data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // size is funct3[1:0]: 0 = byte, 1 = half, 2 = word
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the core (master) and the responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: fault detection, store replication/byte-enables,
// load lane select with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [1:0] off;
  logic       oob, mis, ill;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign off = addr_i[1:0];
  assign oob = addr_i[31:2] >= 30'(DEPTH_WORDS);
  assign mis = ((funct3_i[1:0] == 2'd1) && off[0]) ||
               ((funct3_i[1:0] == 2'd2) && (off != 2'd0));
  assign ill = we_i ? !(funct3_i inside {F3_B, F3_H, F3_W})
                    : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign err_o = oob || mis || ill;

  assign be_o = err_o ? 4'b0000 : byte_en(funct3_i[1:0], off);

  always_comb begin
    case (funct3_i[1:0])
      2'd0:    wdata_o = {4{wdata_i[7:0]}};
      2'd1:    wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
  end

  assign rhalf = off[1] ? rword_i[31:16] : rword_i[15:0];

  // stores and faults always answer with zero data
  always_comb begin
    rdata_o = '0;
    if (!we_i && !err_o) begin
      case (funct3_i)
        F3_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
        F3_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
        F3_W:    rdata_o = rword_i;
        F3_BU:   rdata_o = {24'b0, rbyte};
        F3_HU:   rdata_o = {16'b0, rhalf};
        default: rdata_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accept, wait LATENCY cycles,
// execute against the word array, hold the response until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept, exec, wr_en;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] rword, wrep, ld_data;
  logic [3:0]  be;
  logic        ld_err;

  assign idx   = addr_q[AW+1:2];
  assign rword = mem_q[idx];

  dmem_lane_align #(.DEPTH_WORDS(DEPTH_WORDS)) u_align (
    .we_i    (we_q),
    .funct3_i(f3_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rword_i (rword),
    .be_o    (be),
    .wdata_o (wrep),
    .rdata_o (ld_data),
    .err_o   (ld_err)
  );

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid && bus.req_ready) begin
        accept  = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 2'd0) begin
        exec    = 1'b1;
        rdata_d = ld_data;
        err_d   = ld_err;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a reset landing on the execute edge must drop the store too
  assign wr_en = exec && we_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= wrep[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, randomized traffic against
// a byte-array model, and LATENCY=3 backpressure/reset sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst3;
  dmem_if b1();
  dmem_if b3();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst),  .bus(b1));
  dmem_responder #(.DEPTH_WORDS(64),   .LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

  logic        d_valid [2];
  logic        d_we    [2];
  logic        d_rr    [2];
  logic [2:0]  d_f3    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];

  assign b1.req_valid  = d_valid[0];
  assign b1.req_we     = d_we[0];
  assign b1.req_funct3 = d_f3[0];
  assign b1.req_addr   = d_addr[0];
  assign b1.req_wdata  = d_wdata[0];
  assign b1.resp_ready = d_rr[0];
  assign b3.req_valid  = d_valid[1];
  assign b3.req_we     = d_we[1];
  assign b3.req_funct3 = d_f3[1];
  assign b3.req_addr   = d_addr[1];
  assign b3.req_wdata  = d_wdata[1];
  assign b3.resp_ready = d_rr[1];

  function automatic logic o_rdy(input int s);
    return (s != 0) ? b3.req_ready : b1.req_ready;
  endfunction
  function automatic logic o_rv(input int s);
    return (s != 0) ? b3.resp_valid : b1.resp_valid;
  endfunction
  function automatic logic [31:0] o_rdata(input int s);
    return (s != 0) ? b3.resp_rdata : b1.resp_rdata;
  endfunction
  function automatic logic o_err(input int s);
    return (s != 0) ? b3.resp_err : b1.resp_err;
  endfunction

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Full transaction. edges counts rising edges from the accept edge
  // (inclusive) up to the one after which resp_valid is seen high.
  task automatic txn(input int s, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic er, output int edges);
    int guard = 0;
    @(negedge clk);
    while (!o_rdy(s) && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
    d_valid[s] = 1'b1; d_we[s] = we; d_f3[s] = f3; d_addr[s] = addr; d_wdata[s] = wdata;
    @(posedge clk); #1;
    d_valid[s] = 1'b0;
    edges = 1;
    while (!o_rv(s) && edges < 20) begin @(posedge clk); #1; edges++; end
    rd = o_rdata(s);
    er = o_err(s);
    d_rr[s] = 1'b1;
    @(posedge clk); #1;
    d_rr[s] = 1'b0;
  endtask

  // Reference model: byte-addressed array, rules applied directly.
  logic [7:0] mb [64];

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int sz;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    er = (sz == 0) || (we && f3[2]) || ((addr >> 2) >= 32'd1024);
    if (!er && (int'(addr) % sz) != 0) er = 1'b1;
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mb[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[int'(addr) + i]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endfunction

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer, we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          edges;

    tbl[0]  = '{"sw_deadbeef", 1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{"lw_10",       1'b0, F3_W,   32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{"lb_13",       1'b0, F3_B,   32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{"lbu_13",      1'b0, F3_BU,  32'h13,   32'h0,        32'h000000DE, 1'b0};
    tbl[4]  = '{"lh_12",       1'b0, F3_H,   32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{"lhu_10",      1'b0, F3_HU,  32'h10,   32'h0,        32'h0000BEEF, 1'b0};
    tbl[6]  = '{"sb_11",       1'b1, F3_B,   32'h11,   32'h12345677, 32'h0,        1'b0};
    tbl[7]  = '{"lw_after_sb", 1'b0, F3_W,   32'h10,   32'h0,        32'hDEAD77EF, 1'b0};
    tbl[8]  = '{"lw_mis",      1'b0, F3_W,   32'h12,   32'h0,        32'h0,        1'b1};
    tbl[9]  = '{"sh_mis",      1'b1, F3_H,   32'h11,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[10] = '{"lw_oob",      1'b0, F3_W,   32'h1000, 32'h0,        32'h0,        1'b1};
    tbl[11] = '{"ld_f3_011",   1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1};
    tbl[12] = '{"st_f3_100",   1'b1, 3'b100, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[13] = '{"lw_hi_addr",  1'b0, F3_W,   32'h80000010, 32'h0,    32'h0,        1'b1};
    tbl[14] = '{"sh_last",     1'b1, F3_H,   32'hFFE,  32'h0000CAFE, 32'h0,        1'b0};
    tbl[15] = '{"lhu_last",    1'b0, F3_HU,  32'hFFE,  32'h0,        32'h0000CAFE, 1'b0};
    tbl[16] = '{"lh_last",     1'b0, F3_H,   32'hFFE,  32'h0,        32'hFFFFCAFE, 1'b0};
    tbl[17] = '{"lbu_last",    1'b0, F3_BU,  32'hFFF,  32'h0,        32'h000000CA, 1'b0};
    tbl[18] = '{"lw_unchanged",1'b0, F3_W,   32'h10,   32'h0,        32'hDEAD77EF, 1'b0};

    for (int s = 0; s < 2; s++) begin
      d_valid[s] = 1'b0; d_we[s] = 1'b0; d_rr[s] = 1'b0;
      d_f3[s] = '0; d_addr[s] = '0; d_wdata[s] = '0;
    end

    // reset
    rst = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(o_rdy(0)), 32'd0);
    chk("rst_valid",  32'(o_rv(0)),  32'd0);
    chk("rst_rdata",  o_rdata(0),    32'd0);
    chk("rst_err",    32'(o_err(0)), 32'd0);
    chk("rst3_ready", 32'(o_rdy(1)), 32'd0);
    rst = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready",  32'(o_rdy(0)), 32'd1);
    chk("post_rst_valid",  32'(o_rv(0)),  32'd0);
    chk("post_rst3_ready", 32'(o_rdy(1)), 32'd1);

    // directed table, LATENCY=1
    foreach (tbl[i]) begin
      txn(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, edges);
      chk({tbl[i].nm, "_rdata"}, rd, tbl[i].rd);
      chk({tbl[i].nm, "_err"},   32'(er), 32'(tbl[i].er));
      chk({tbl[i].nm, "_lat"},   32'(edges), 32'd2);
    end

    // randomized traffic over words 0..15 plus out-of-range addresses
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(1'b1, F3_W, 32'(w*4), wd, erd, eer);
      txn(0, 1'b1, F3_W, 32'(w*4), wd, rd, er, edges);
      chk("init_err", 32'(er), 32'(eer));
    end
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
      else                           addr = 32'($urandom_range(0, 63));
      wd = $urandom;
      model(we, f3, addr, wd, erd, eer);
      txn(0, we, f3, addr, wd, rd, er, edges);
      chk("rnd_rdata", rd, erd);
      chk("rnd_err",   32'(er), 32'(eer));
    end

    // LATENCY=3: normal store, response held under backpressure
    txn(1, 1'b1, F3_W, 32'h20, 32'h11111111, rd, er, edges);
    chk("l3_sw_lat", 32'(edges), 32'd4);
    chk("l3_sw_err", 32'(er), 32'd0);

    @(negedge clk);
    d_valid[1] = 1'b1; d_we[1] = 1'b0; d_f3[1] = F3_W; d_addr[1] = 32'h20;
    @(posedge clk); #1;
    d_valid[1] = 1'b0;
    edges = 1;
    while (!o_rv(1) && edges < 20) begin @(posedge clk); #1; edges++; end
    chk("l3_lw_lat", 32'(edges), 32'd4);
    d_valid[1] = 1'b1; d_addr[1] = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("l3_hold_valid", 32'(o_rv(1)),  32'd1);
      chk("l3_hold_rdata", o_rdata(1),    32'h11111111);
      chk("l3_hold_err",   32'(o_err(1)), 32'd0);
      chk("l3_hold_ready", 32'(o_rdy(1)), 32'd0);
    end
    d_rr[1] = 1'b1;
    @(posedge clk); #1;
    d_rr[1] = 1'b0;
    chk("l3_hs_valid", 32'(o_rv(1)),  32'd0);
    chk("l3_hs_ready", 32'(o_rdy(1)), 32'd1);
    @(posedge clk); #1;
    d_valid[1] = 1'b0;
    chk("l3_accepted", 32'(o_rdy(1)), 32'd0);
    edges = 1;
    while (!o_rv(1) && edges < 20) begin @(posedge clk); #1; edges++; end
    chk("l3_second_lat",   32'(edges), 32'd4);
    chk("l3_second_rdata", o_rdata(1), 32'h11111111);
    d_rr[1] = 1'b1;
    @(posedge clk); #1;
    d_rr[1] = 1'b0;

    // reset during WAIT of a store drops it
    @(negedge clk);
    d_valid[1] = 1'b1; d_we[1] = 1'b1; d_f3[1] = F3_W; d_addr[1] = 32'h20; d_wdata[1] = 32'h22222222;
    @(posedge clk); #1;
    d_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("l3_rst_ready", 32'(o_rdy(1)), 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk("l3_rst_valid", 32'(o_rv(1)), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("l3_idle_valid", 32'(o_rv(1)), 32'd0);
    txn(1, 1'b0, F3_W, 32'h20, 32'h0, rd, er, edges);
    chk("l3_dropped_store", rd, 32'h11111111);
    chk("l3_dropped_err",   32'(er), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle RISC-V core's load/store path. The core initiates; this block accepts, executes and answers.
- Accepts one request at a time over a valid/ready handshake and performs RV32I byte/half/word accesses on an internal little-endian word array.
- Returns read data or an error after a programmable latency, holding the response until the core accepts it.
- Sits beside the ALU: the ALU result drives req_addr and the rs2 value drives req_wdata.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of 2.
- LATENCY, 1, cycles from request acceptance to resp_valid rising; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; data is taken from the low bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load result, already extended; 0 for stores and for errors.
- resp_err  out  1  access fault.

Behaviour:
- Reset (rst=1 at the edge):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready is forced to 0 while rst=1.
  - Array contents are not cleared.
  - Reset mid-transaction abandons the transaction. A store that has not yet committed is dropped; a store that already committed is kept.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/funct3/addr/wdata, load cnt=LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. If cnt==0, execute the access, register the response and go to RESP. Otherwise decrement cnt.
  - RESP: resp_valid=1, req_ready=0. On resp_ready, go to IDLE. resp_valid, resp_rdata and resp_err stay stable until that handshake.
- Minimum timing: with LATENCY=1, resp_valid rises 2 edges after the accept edge. Back-to-back throughput is one transaction per LATENCY+2 cycles; there is no request/response overlap.
- Error checks, evaluated on the captured request:
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal funct3: loads with 011, 110 or 111; stores with anything other than 000/001/010.
  - On error: resp_err=1, resp_rdata=0, no array write.
- Store commit:
  - Written in the execute cycle using byte-enables derived from addr[1:0] and size.
  - SB: lane = addr[1:0], data = wdata[7:0].
  - SH: lanes {1,0} or {3,2}, data = wdata[15:0].
  - SW: all four lanes.
- Load:
  - Reads the word in the execute cycle, then selects the lane.
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - A load issued after a committed store to the same address returns the new data.
- Address bits above log2(DEPTH_WORDS)+1 are not used for indexing; they only feed the range check.
- Inputs during WAIT/RESP are ignored, and req_valid held high is not accepted until IDLE.
- resp_ready asserted while resp_valid=0 has no effect.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding IDLE/WAIT/RESP.
  - Function computing the 4-bit byte-enable from size and offset.
- Sub-module dmem_lane_align (combinational):
  - Store path: wdata replication plus byte-enable.
  - Load path: lane select plus sign/zero extension.
  - Error detection.
- The FSM and the array stay in dmem_responder.

Test Plan:
1. Reset with LATENCY=1 -> req_ready=0 during rst, 1 after; resp_valid=0.
2. SW 0xDEADBEEF @0x10 then LW @0x10 -> rdata=0xDEADBEEF, err=0. resp_valid rises 2 edges after each accept.
3. After case 2: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
4. SB 0x12345677 @0x11 then LW @0x10 -> 0xDEAD77EF.
5. LW @0x12, SH @0x11, LW @(DEPTH_WORDS*4), load with funct3=011:
   - Each returns err=1, rdata=0.
   - A follow-up LW @0x10 is unchanged.
6. LATENCY=3 with resp_ready held low 5 cycles:
   - resp_valid rises 4 edges after accept and stays stable.
   - A new req_valid is not accepted until the edge after resp_ready.
   - rst asserted in WAIT of an SW drops the store.
